beta_lsu: RTL and testbench

//  Parametrised load/store execution unit for the multi-cycle Beta core.

---
 rtl/beta_pkg.sv | 14 +
 rtl/beta_lsu_if.sv | 17 +
 rtl/lsu_cmd_fifo.sv | 43 ++++
 rtl/beta_lsu.sv | 156 +++++++++++++++
 tb/tb_beta_lsu.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/beta_pkg.sv
// Shared Beta-core types and helpers used by the load/store unit.
package beta_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, RESP} lsu_state_t;

   localparam int REGSEL_W = 5;
   localparam int SEXT_W   = 64;

   // Widest supported datapath; callers cast down to DWIDTH.
   function automatic logic [SEXT_W-1:0] sext16(input logic [15:0] v);
      return {{(SEXT_W-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/beta_lsu_if.sv
// Memory-controller Valid/Ready bus between the LSU (master) and memory (slave).
interface beta_lsu_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32
);
   logic [AWIDTH-1:0] mem_addr;
   logic              mem_rw;
   logic              mem_valid;
   logic [DWIDTH-1:0] mem_wdata;
   logic [DWIDTH-1:0] mem_rdata;
   logic              mem_ready;

   modport master (output mem_addr, mem_rw, mem_valid, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_addr, mem_rw, mem_valid, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface

// File: rtl/lsu_cmd_fifo.sv
// In-order command FIFO; a push while full is dropped even if a pop happens too.
module lsu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW:0]      wrPtr;
   logic [PW:0]      rdPtr;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
   assign rdata = store[rdPtr[PW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push && !full)
            wrPtr <= wrPtr + (PW+1)'(1);
         if (pop && !empty)
            rdPtr <= rdPtr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         store[wrPtr[PW-1:0]] <= wdata;
   end

endmodule

// File: rtl/beta_lsu.sv
// Beta load/store unit: buffers LD/ST commands, forms EA, runs one memory
// transaction per command and writes load data back to the register file.
module beta_lsu
   import beta_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_store,
   input  logic [DWIDTH-1:0]   cmd_base,
   input  logic [15:0]         cmd_offset,
   input  logic [DWIDTH-1:0]   cmd_sdata,
   input  logic [REGSEL_W-1:0] cmd_rc,
   output logic                busy,
   output logic                done,
   output logic [REGSEL_W-1:0] done_rc,
   output logic                err,
   beta_lsu_if.master          mem,
   output logic                rf_wen,
   output logic [REGSEL_W-1:0] rf_wsel,
   output logic [DWIDTH-1:0]   rf_wdata
);
   localparam int CW = 1 + DWIDTH + 16 + DWIDTH + REGSEL_W;
   localparam int TW = $clog2(TIMEOUT + 1);

   lsu_state_t          state;
   logic [TW-1:0]       timer;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                popHead;
   logic [CW-1:0]       headData;

   logic                hStore;
   logic [DWIDTH-1:0]   hBase;
   logic [15:0]         hOff;
   logic [DWIDTH-1:0]   hSdata;
   logic [REGSEL_W-1:0] hRc;

   logic                wStore;
   logic [DWIDTH-1:0]   wBase;
   logic [15:0]         wOff;
   logic [DWIDTH-1:0]   wSdata;
   logic [REGSEL_W-1:0] wRc;

   logic [DWIDTH-1:0]   ea;
   logic                eaHigh;

   assign popHead   = (state == IDLE) && !fifoEmpty;
   assign cmd_ready = !fifoFull;
   assign busy      = !fifoEmpty || (state != IDLE);
   assign {hStore, hBase, hOff, hSdata, hRc} = headData;

   lsu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (popHead),
      .wdata ({cmd_store, cmd_base, cmd_offset, cmd_sdata, cmd_rc}),
      .rdata (headData),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   always_comb begin
      ea     = wBase + DWIDTH'(sext16(wOff));
      eaHigh = (ea >> AWIDTH) != '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         wStore        <= 1'b0;
         wBase         <= '0;
         wOff          <= '0;
         wSdata        <= '0;
         wRc           <= '0;
         done          <= 1'b0;
         done_rc       <= '0;
         err           <= 1'b0;
         rf_wen        <= 1'b0;
         rf_wsel       <= '0;
         rf_wdata      <= '0;
         mem.mem_addr  <= '0;
         mem.mem_rw    <= 1'b0;
         mem.mem_valid <= 1'b0;
         mem.mem_wdata <= '0;
      end else begin
         // Pulse outputs are set on the edge that enters their state.
         done          <= 1'b0;
         err           <= 1'b0;
         rf_wen        <= 1'b0;
         mem.mem_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifoEmpty) begin
                  wStore <= hStore;
                  wBase  <= hBase;
                  wOff   <= hOff;
                  wSdata <= hSdata;
                  wRc    <= hRc;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (eaHigh) begin
                  done    <= 1'b1;
                  err     <= 1'b1;
                  done_rc <= wRc;
                  state   <= RESP;
               end else begin
                  mem.mem_addr  <= AWIDTH'(ea);
                  mem.mem_rw    <= !wStore;
                  mem.mem_wdata <= wStore ? wSdata : '0;
                  mem.mem_valid <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (mem.mem_ready) begin
                  done    <= 1'b1;
                  done_rc <= wRc;
                  rf_wen  <= !wStore;
                  rf_wsel <= wRc;
                  if (!wStore)
                     rf_wdata <= mem.mem_rdata;
                  state   <= RESP;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  done    <= 1'b1;
                  err     <= 1'b1;
                  done_rc <= wRc;
                  state   <= RESP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_beta_lsu.sv
// Directed self-checking bench for beta_lsu (DWIDTH=32, AWIDTH=8, DEPTH=4, TIMEOUT=15).
module tb_beta_lsu;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int DP = 4;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_store = 1'b0;
   logic [DW-1:0] cmd_base = '0;
   logic [15:0]   cmd_offset = '0;
   logic [DW-1:0] cmd_sdata = '0;
   logic [4:0]    cmd_rc = '0;
   logic          busy;
   logic          done;
   logic [4:0]    done_rc;
   logic          err;
   logic          rf_wen;
   logic [4:0]    rf_wsel;
   logic [DW-1:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   beta_lsu_if #(.AWIDTH(AW), .DWIDTH(DW)) memIf ();

   beta_lsu #(
      .DWIDTH  (DW),
      .AWIDTH  (AW),
      .DEPTH   (DP),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_store  (cmd_store),
      .cmd_base   (cmd_base),
      .cmd_offset (cmd_offset),
      .cmd_sdata  (cmd_sdata),
      .cmd_rc     (cmd_rc),
      .busy       (busy),
      .done       (done),
      .done_rc    (done_rc),
      .err        (err),
      .mem        (memIf.master),
      .rf_wen     (rf_wen),
      .rf_wsel    (rf_wsel),
      .rf_wdata   (rf_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command for a single edge.
   task automatic push(input logic st, input logic [DW-1:0] base, input logic [15:0] off,
                       input logic [DW-1:0] sd, input logic [4:0] rc);
      cmd_valid  = 1'b1;
      cmd_store  = st;
      cmd_base   = base;
      cmd_offset = off;
      cmd_sdata  = sd;
      cmd_rc     = rc;
      tick();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      int acc;
      int nDone;
      int nPulse;
      logic [4:0] expRc [5];

      memIf.mem_ready = 1'b0;
      memIf.mem_rdata = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_valid", memIf.mem_valid, 0);
      chk("rst_rf_wen", rf_wen, 0);
      chk("rst_mem_addr", memIf.mem_addr, 0);

      // 1: LD 0x10+4 -> 0x14, ready two cycles after valid
      push(1'b0, 32'h10, 16'd4, 32'h0, 5'd3);
      chk("t1_busy", busy, 1);
      chk("t1_idle_valid", memIf.mem_valid, 0);
      tick();
      chk("t1_addr_valid", memIf.mem_valid, 0);
      tick();
      chk("t1_req_valid", memIf.mem_valid, 1);
      chk("t1_req_addr", memIf.mem_addr, 8'h14);
      chk("t1_req_rw", memIf.mem_rw, 1);
      chk("t1_req_wdata", memIf.mem_wdata, 0);
      tick();
      chk("t1_wait_valid", memIf.mem_valid, 0);
      chk("t1_wait_addr", memIf.mem_addr, 8'h14);
      tick();
      memIf.mem_ready = 1'b1;
      memIf.mem_rdata = 32'hDEADBEEF;
      tick();
      memIf.mem_ready = 1'b0;
      chk("t1_done", done, 1);
      chk("t1_done_rc", done_rc, 3);
      chk("t1_err", err, 0);
      chk("t1_rf_wen", rf_wen, 1);
      chk("t1_rf_wsel", rf_wsel, 3);
      chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
      tick();
      chk("t1_done_pulse", done, 0);
      chk("t1_rf_wen_pulse", rf_wen, 0);
      chk("t1_idle_busy", busy, 0);

      // 2: ST 0x20 + (-1) -> 0x1F; ready raised early is ignored until WAIT
      push(1'b1, 32'h20, 16'hFFFF, 32'h12345678, 5'd7);
      tick();
      memIf.mem_ready = 1'b1;
      chk("t2_addr_valid", memIf.mem_valid, 0);
      tick();
      chk("t2_req_valid", memIf.mem_valid, 1);
      chk("t2_req_addr", memIf.mem_addr, 8'h1F);
      chk("t2_req_rw", memIf.mem_rw, 0);
      chk("t2_req_wdata", memIf.mem_wdata, 32'h12345678);
      chk("t2_req_done", done, 0);
      tick();
      chk("t2_wait_done", done, 0);
      chk("t2_wait_rf_wen", rf_wen, 0);
      tick();
      memIf.mem_ready = 1'b0;
      chk("t2_done", done, 1);
      chk("t2_done_rc", done_rc, 7);
      chk("t2_err", err, 0);
      chk("t2_rf_wen", rf_wen, 0);
      tick();
      chk("t2_idle_rf_wen", rf_wen, 0);

      // 3: LD 0xFF+1 = 0x100 is out of range
      push(1'b0, 32'hFF, 16'd1, 32'h0, 5'd9);
      tick();
      chk("t3_addr_valid", memIf.mem_valid, 0);
      tick();
      chk("t3_done", done, 1);
      chk("t3_err", err, 1);
      chk("t3_done_rc", done_rc, 9);
      chk("t3_rf_wen", rf_wen, 0);
      chk("t3_valid", memIf.mem_valid, 0);
      tick();
      chk("t3_done_pulse", done, 0);
      chk("t3_err_pulse", err, 0);
      chk("t3_valid_after", memIf.mem_valid, 0);

      // 4: LD with memory never ready -> timeout TO+1 cycles after REQ
      push(1'b0, 32'h0, 16'd5, 32'h0, 5'd4);
      tick();
      tick();
      chk("t4_req_valid", memIf.mem_valid, 1);
      nPulse = 0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (done) nPulse++;
      end
      chk("t4_no_early_done", nPulse, 0);
      tick();
      chk("t4_done", done, 1);
      chk("t4_err", err, 1);
      chk("t4_done_rc", done_rc, 4);
      chk("t4_rf_wen", rf_wen, 0);
      tick();
      chk("t4_done_pulse", done, 0);
      push(1'b0, 32'h30, 16'd0, 32'h0, 5'd5);
      tick();
      tick();
      chk("t4b_req_addr", memIf.mem_addr, 8'h30);
      memIf.mem_ready = 1'b1;
      memIf.mem_rdata = 32'hCAFEF00D;
      tick();
      tick();
      memIf.mem_ready = 1'b0;
      chk("t4b_done", done, 1);
      chk("t4b_err", err, 0);
      chk("t4b_rf_wdata", rf_wdata, 32'hCAFEF00D);
      chk("t4b_rf_wsel", rf_wsel, 5);
      tick();

      // 5: stalled memory, DEPTH+2 back-to-back pushes
      acc = 0;
      for (int i = 0; i < DP + 2; i++) begin
         cmd_valid  = 1'b1;
         cmd_store  = 1'b1;
         cmd_base   = 32'(i);
         cmd_offset = 16'h0;
         cmd_sdata  = 32'(i + 100);
         cmd_rc     = 5'(10 + i);
         if (cmd_ready) acc++;
         tick();
      end
      cmd_valid = 1'b0;
      chk("t5_accepted", acc, DP + 1);
      chk("t5_cmd_ready", cmd_ready, 0);
      chk("t5_busy", busy, 1);
      for (int i = 0; i < 5; i++) expRc[i] = 5'(10 + i);
      memIf.mem_ready = 1'b1;
      nDone = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (done) begin
            if (nDone < 5) chk("t5_done_rc", done_rc, expRc[nDone]);
            chk("t5_err", err, 0);
            nDone++;
         end
      end
      memIf.mem_ready = 1'b0;
      chk("t5_done_count", nDone, 5);
      chk("t5_busy_end", busy, 0);
      chk("t5_cmd_ready_end", cmd_ready, 1);

      // 6: reset during WAIT with two commands still queued
      push(1'b0, 32'h1, 16'd0, 32'h0, 5'd20);
      push(1'b0, 32'h2, 16'd0, 32'h0, 5'd21);
      push(1'b0, 32'h3, 16'd0, 32'h0, 5'd22);
      tick();
      chk("t6_wait_valid", memIf.mem_valid, 0);
      chk("t6_cmd_ready_pre", cmd_ready, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", memIf.mem_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_addr", memIf.mem_addr, 0);
      tick();
      tick();
      reset = 1'b0;
      memIf.mem_ready = 1'b1;
      nPulse = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done || memIf.mem_valid) nPulse++;
      end
      memIf.mem_ready = 1'b0;
      chk("t6_no_activity", nPulse, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cmd_ready", cmd_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
